// File: rtl/sram_bist_pkg.sv
// Shared definitions for the March C- SRAM BIST: FSM states, element encoding
// and default geometry.
package sram_bist_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 64;
   localparam int unsigned DEF_ADDR_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   typedef logic [2:0] elem_idx_t;

   localparam elem_idx_t LAST_ELEM = 3'd5;

   typedef struct packed {
      logic down;
      logic has_rd;
      logic has_wr;
      logic rd_pol;
      logic wr_pol;
   } elem_t;

   function automatic logic is_down(elem_idx_t idx);
      return (idx == 3'd3) || (idx == 3'd4);
   endfunction

   // M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 up(r0)
   function automatic elem_t march_elem(elem_idx_t idx);
      elem_t e;
      e.down = is_down(idx);
      case (idx)
         3'd0:    begin e.has_rd = 1'b0; e.has_wr = 1'b1; e.rd_pol = 1'b0; e.wr_pol = 1'b0; end
         3'd1:    begin e.has_rd = 1'b1; e.has_wr = 1'b1; e.rd_pol = 1'b0; e.wr_pol = 1'b1; end
         3'd2:    begin e.has_rd = 1'b1; e.has_wr = 1'b1; e.rd_pol = 1'b1; e.wr_pol = 1'b0; end
         3'd3:    begin e.has_rd = 1'b1; e.has_wr = 1'b1; e.rd_pol = 1'b0; e.wr_pol = 1'b1; end
         3'd4:    begin e.has_rd = 1'b1; e.has_wr = 1'b1; e.rd_pol = 1'b1; e.wr_pol = 1'b0; end
         default: begin e.has_rd = 1'b1; e.has_wr = 1'b0; e.rd_pol = 1'b0; e.wr_pol = 1'b0; end
      endcase
      return e;
   endfunction

endpackage

// File: rtl/sram_march_bist_if.sv
// SRAM BIST port bundle: master = BIST controller, slave = SRAM.
interface sram_march_bist_if
   import sram_bist_pkg::*;
#(
   parameter int unsigned P_DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned P_ADDR_WIDTH = DEF_ADDR_WIDTH
);

   logic                    A_BIST_EN;
   logic                    A_BIST_MEN;
   logic                    A_BIST_WEN;
   logic                    A_BIST_REN;
   logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR;
   logic [P_DATA_WIDTH-1:0] A_BIST_DIN;
   logic [P_DATA_WIDTH-1:0] A_BIST_BM;
   logic [P_DATA_WIDTH-1:0] A_DOUT;

   modport master (
      output A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN,
      output A_BIST_ADDR, A_BIST_DIN, A_BIST_BM,
      input  A_DOUT
   );

   modport slave (
      input  A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN,
      input  A_BIST_ADDR, A_BIST_DIN, A_BIST_BM,
      output A_DOUT
   );

endinterface

// File: rtl/sram_bist_cmp.sv
// Read-data checker: registers the expected word with the read, compares
// A_DOUT one cycle later and captures the first failing address.
module sram_bist_cmp
   import sram_bist_pkg::*;
#(
   parameter int unsigned P_DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned P_ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    rd_vld,
   input  logic                    rd_pol,
   input  logic [P_ADDR_WIDTH-1:0] rd_addr,
   input  logic [P_DATA_WIDTH-1:0] dout,
   output logic                    fail,
   output logic [P_ADDR_WIDTH-1:0] fail_addr
);

   logic                    chk_vld;
   logic [P_DATA_WIDTH-1:0] chk_exp;
   logic [P_ADDR_WIDTH-1:0] chk_addr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chk_vld   <= 1'b0;
         chk_exp   <= '0;
         chk_addr  <= '0;
         fail      <= 1'b0;
         fail_addr <= '0;
      end else begin
         chk_vld  <= rd_vld;
         chk_exp  <= {P_DATA_WIDTH{rd_pol}};
         chk_addr <= rd_addr;
         if (clear) begin
            fail      <= 1'b0;
            fail_addr <= '0;
         end else if (chk_vld && (dout != chk_exp)) begin
            fail <= 1'b1;
            if (!fail) fail_addr <= chk_addr;
         end
      end
   end

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST controller: one registered SRAM operation per cycle across six
// March elements, with a one-cycle drain for the final read compare.
module sram_march_bist
   import sram_bist_pkg::*;
#(
   parameter int unsigned P_DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned P_ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                    A_BIST_CLK,
   input  logic                    A_BIST_RST,
   input  logic                    START,
   sram_march_bist_if.master       mem,
   output logic                    BUSY,
   output logic                    DONE,
   output logic                    FAIL,
   output logic [P_ADDR_WIDTH-1:0] FAIL_ADDR
);

   state_t                  state_q, state_d;
   elem_idx_t               elem_q, elem_d;
   logic [P_ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic                    phase_q, phase_d;
   logic                    last_q, last_d;
   logic                    en_q, en_d, men_q, men_d, wen_q, wen_d, ren_q, ren_d;
   logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [P_DATA_WIDTH-1:0] din_q, din_d, bm_q, bm_d;
   logic                    rd_pol_q, rd_pol_d;
   logic                    done_q, done_d;

   logic                    start_ok, issue, is_rd, is_wr, addr_end, second_pending;
   elem_idx_t               cur_elem, elem_inc;
   logic [P_ADDR_WIDTH-1:0] cur_ptr;
   logic                    cur_phase;
   elem_t                   e;

   always_ff @(posedge A_BIST_CLK or posedge A_BIST_RST) begin
      if (A_BIST_RST) begin
         state_q  <= ST_IDLE;
         elem_q   <= '0;
         ptr_q    <= '0;
         phase_q  <= 1'b0;
         last_q   <= 1'b0;
         en_q     <= 1'b0;
         men_q    <= 1'b0;
         wen_q    <= 1'b0;
         ren_q    <= 1'b0;
         addr_q   <= '0;
         din_q    <= '0;
         bm_q     <= '0;
         rd_pol_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         elem_q   <= elem_d;
         ptr_q    <= ptr_d;
         phase_q  <= phase_d;
         last_q   <= last_d;
         en_q     <= en_d;
         men_q    <= men_d;
         wen_q    <= wen_d;
         ren_q    <= ren_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         bm_q     <= bm_d;
         rd_pol_q <= rd_pol_d;
         done_q   <= done_d;
      end
   end

   // The accepting edge already registers op 0, so the pointer is forced to
   // the March origin when START is taken.
   always_comb begin
      start_ok       = START && ((state_q == ST_IDLE) || (state_q == ST_DONE));
      cur_elem       = start_ok ? '0 : elem_q;
      cur_ptr        = start_ok ? '0 : ptr_q;
      cur_phase      = start_ok ? 1'b0 : phase_q;
      e              = march_elem(cur_elem);
      is_rd          = e.has_rd && !cur_phase;
      is_wr          = e.has_wr && (cur_phase || !e.has_rd);
      addr_end       = e.down ? (cur_ptr == '0) : (cur_ptr == '1);
      second_pending = e.has_rd && e.has_wr && !cur_phase;
      elem_inc       = cur_elem + 3'd1;

      state_d  = state_q;
      elem_d   = elem_q;
      ptr_d    = ptr_q;
      phase_d  = phase_q;
      last_d   = last_q;
      en_d     = en_q;
      men_d    = 1'b0;
      wen_d    = 1'b0;
      ren_d    = 1'b0;
      addr_d   = '0;
      din_d    = '0;
      bm_d     = '0;
      rd_pol_d = 1'b0;
      done_d   = done_q;
      issue    = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_ok) begin
               state_d = ST_RUN;
               en_d    = 1'b1;
               done_d  = 1'b0;
               issue   = 1'b1;
            end
         end
         ST_RUN: begin
            if (last_q) state_d = ST_DRAIN;
            else        issue   = 1'b1;
         end
         ST_DRAIN: begin
            state_d = ST_DONE;
            en_d    = 1'b0;
            done_d  = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      if (issue) begin
         men_d    = 1'b1;
         wen_d    = is_wr;
         ren_d    = is_rd;
         addr_d   = cur_ptr;
         din_d    = is_wr ? {P_DATA_WIDTH{e.wr_pol}} : '0;
         bm_d     = is_wr ? '1 : '0;
         rd_pol_d = e.rd_pol;
         last_d   = (cur_elem == LAST_ELEM) && addr_end && !second_pending;
         elem_d   = cur_elem;
         ptr_d    = cur_ptr;
         phase_d  = 1'b0;
         if (second_pending) begin
            phase_d = 1'b1;
         end else if (addr_end) begin
            elem_d = elem_inc;
            ptr_d  = is_down(elem_inc) ? '1 : '0;
         end else begin
            ptr_d  = e.down ? cur_ptr - P_ADDR_WIDTH'(1) : cur_ptr + P_ADDR_WIDTH'(1);
         end
      end
   end

   sram_bist_cmp #(
      .P_DATA_WIDTH(P_DATA_WIDTH),
      .P_ADDR_WIDTH(P_ADDR_WIDTH)
   ) u_cmp (
      .clk      (A_BIST_CLK),
      .rst      (A_BIST_RST),
      .clear    (start_ok),
      .rd_vld   (ren_q),
      .rd_pol   (rd_pol_q),
      .rd_addr  (addr_q),
      .dout     (mem.A_DOUT),
      .fail     (FAIL),
      .fail_addr(FAIL_ADDR)
   );

   assign mem.A_BIST_EN   = en_q;
   assign mem.A_BIST_MEN  = men_q;
   assign mem.A_BIST_WEN  = wen_q;
   assign mem.A_BIST_REN  = ren_q;
   assign mem.A_BIST_ADDR = addr_q;
   assign mem.A_BIST_DIN  = din_q;
   assign mem.A_BIST_BM   = bm_q;
   assign BUSY            = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign DONE            = done_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// Scoreboard bench for sram_march_bist against a 256x64 behavioural SRAM with
// injectable stuck-at faults.
`timescale 1ns/1ps
module tb_sram_march_bist;
   import sram_bist_pkg::*;

   localparam int unsigned DW = 64;
   localparam int unsigned AW = 8;
   localparam int unsigned DEPTH = 256;
   localparam int DONE_LAT = 10 * DEPTH + 1;

   typedef struct packed {
      logic          en;
      logic          wen;
      logic          ren;
      logic [AW-1:0] addr;
      logic [DW-1:0] din;
      logic [DW-1:0] bm;
   } op_t;

   typedef struct {
      int            start_cyc;
      logic          fail;
      logic [AW-1:0] fail_addr;
   } stat_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          busy, done, fail;
   logic [AW-1:0] fail_addr;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   n_wr = 0;
   int   n_rd = 0;
   bit   run_done = 1'b0;
   logic done_prev = 1'b0;

   op_t   exp_ops[$];
   stat_t exp_stat[$];

   logic [DW-1:0] ram [DEPTH];
   logic [DW-1:0] sa0 [DEPTH];
   logic [DW-1:0] sa1 [DEPTH];

   sram_march_bist_if #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW)) mem_if ();

   sram_march_bist #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW)) dut (
      .A_BIST_CLK(clk),
      .A_BIST_RST(rst),
      .START     (start),
      .mem       (mem_if),
      .BUSY      (busy),
      .DONE      (done),
      .FAIL      (fail),
      .FAIL_ADDR (fail_addr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (mem_if.A_BIST_MEN && mem_if.A_BIST_WEN)
         ram[mem_if.A_BIST_ADDR] <= (ram[mem_if.A_BIST_ADDR] & ~mem_if.A_BIST_BM) |
                                    (mem_if.A_BIST_DIN & mem_if.A_BIST_BM);
      if (mem_if.A_BIST_MEN && mem_if.A_BIST_REN)
         mem_if.A_DOUT <= (ram[mem_if.A_BIST_ADDR] | sa1[mem_if.A_BIST_ADDR]) &
                          ~sa0[mem_if.A_BIST_ADDR];
   end

   function automatic void check(input string name, input logic [255:0] got, input logic [255:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
      end
   endfunction

   function automatic void push_op(input bit we, input int unsigned a, input bit pol);
      op_t o;
      o.en   = 1'b1;
      o.wen  = we;
      o.ren  = !we;
      o.addr = AW'(a);
      o.din  = we ? {DW{pol}} : '0;
      o.bm   = we ? '1 : '0;
      exp_ops.push_back(o);
   endfunction

   function automatic void push_march();
      for (int i = 0; i < DEPTH; i++) push_op(1'b1, i, 1'b0);
      for (int i = 0; i < DEPTH; i++) begin push_op(1'b0, i, 1'b0); push_op(1'b1, i, 1'b1); end
      for (int i = 0; i < DEPTH; i++) begin push_op(1'b0, i, 1'b0); push_op(1'b1, i, 1'b0); end
      for (int i = DEPTH - 1; i >= 0; i--) begin push_op(1'b0, i, 1'b0); push_op(1'b1, i, 1'b1); end
      for (int i = DEPTH - 1; i >= 0; i--) begin push_op(1'b0, i, 1'b0); push_op(1'b1, i, 1'b0); end
      for (int i = 0; i < DEPTH; i++) push_op(1'b0, i, 1'b0);
   endfunction

   // Monitor: pops one expected op per SRAM access, one status record per DONE rise.
   always @(negedge clk) begin
      op_t   act, e;
      stat_t s;
      if (rst) begin
         n_wr = 0;
         n_rd = 0;
      end else begin
         if (mem_if.A_BIST_MEN) begin
            act = {mem_if.A_BIST_EN, mem_if.A_BIST_WEN, mem_if.A_BIST_REN,
                   mem_if.A_BIST_ADDR, mem_if.A_BIST_DIN, mem_if.A_BIST_BM};
            if (mem_if.A_BIST_WEN) n_wr++;
            if (mem_if.A_BIST_REN) n_rd++;
            if (exp_ops.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL op_unexpected: got %h want no operation (t=%0t)", act, $time);
            end else begin
               e = exp_ops.pop_front();
               check("op", 256'(act), 256'(e));
            end
         end
         if (done && !done_prev) begin
            if (exp_stat.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL done_unexpected: got DONE=1 want no completion (t=%0t)", $time);
            end else begin
               s = exp_stat.pop_front();
               check("done_latency", 256'(cyc - s.start_cyc), 256'(DONE_LAT));
               check("fail_flag", 256'(fail), 256'(s.fail));
               check("fail_addr", 256'(fail_addr), 256'(s.fail_addr));
               check("write_count", 256'(n_wr), 256'(DEPTH * 5));
               check("read_count", 256'(n_rd), 256'(DEPTH * 5));
               check("busy_at_done", 256'({busy, mem_if.A_BIST_EN}), 256'(0));
            end
            n_wr = 0;
            n_rd = 0;
            run_done = 1'b1;
         end
      end
      done_prev = done;
   end

   task automatic launch(input bit push_stat, input logic efail, input logic [AW-1:0] eaddr);
      stat_t s;
      push_march();
      @(negedge clk);
      s.start_cyc = cyc + 1;
      s.fail      = efail;
      s.fail_addr = eaddr;
      if (push_stat) exp_stat.push_back(s);
      run_done = 1'b0;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", 256'({busy, mem_if.A_BIST_EN, done, fail}), 256'(4'b1100));
   endtask

   task automatic wait_done();
      for (int i = 0; i < DONE_LAT + 50; i++) begin
         if (run_done) break;
         @(negedge clk);
      end
      check("done_seen", 256'(run_done), 256'(1));
   endtask

   task automatic run(input logic efail, input logic [AW-1:0] eaddr, input bit poke);
      launch(1'b1, efail, eaddr);
      if (poke) begin
         repeat (99) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      wait_done();
      repeat (3) @(negedge clk);
   endtask

   function automatic logic [255:0] all_outs();
      return 256'({mem_if.A_BIST_EN, mem_if.A_BIST_MEN, mem_if.A_BIST_WEN, mem_if.A_BIST_REN,
                   mem_if.A_BIST_ADDR, mem_if.A_BIST_DIN, mem_if.A_BIST_BM,
                   busy, done, fail, fail_addr});
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got simulation still running want finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         ram[i] = {$urandom, $urandom};
         sa0[i] = '0;
         sa1[i] = '0;
      end

      repeat (3) @(negedge clk);
      check("reset_outputs", all_outs(), 256'(0));
      rst = 1'b0;
      @(negedge clk);
      check("idle_outputs", all_outs(), 256'(0));

      run(1'b0, 8'h00, 1'b0);

      sa1[8'h37][5] = 1'b1;
      run(1'b1, 8'h37, 1'b0);
      sa1[8'h37] = '0;

      sa0[8'h10][0]  = 1'b1;
      sa0[8'hF0][63] = 1'b1;
      run(1'b1, 8'h10, 1'b0);
      sa0[8'h10] = '0;
      sa0[8'hF0] = '0;

      run(1'b0, 8'h00, 1'b1);

      launch(1'b0, 1'b0, 8'h00);
      repeat (698) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check("async_reset_outputs", all_outs(), 256'(0));
      repeat (3) @(negedge clk);
      exp_ops.delete();
      check("reset_hold_outputs", all_outs(), 256'(0));
      rst = 1'b0;
      repeat (30) @(negedge clk);
      check("post_reset_idle", all_outs(), 256'(0));

      run(1'b0, 8'h00, 1'b0);

      check("ops_drained", 256'(exp_ops.size()), 256'(0));
      check("status_drained", 256'(exp_stat.size()), 256'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
